// File: rtl/sram_ctrl.sv
// 32-bit bus to 16-bit asynchronous SRAM bridge: each word is two halfword accesses, low half first.
// Optional SRAM_HALF_SKIP_EN: halves whose byte enables are all zero are not accessed.
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_req,
    input  logic        bus_write,
    input  logic [18:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_byteenable,
    output logic        bus_ready,
    output logic [31:0] bus_rdata,
    output logic [17:0] sram_addr,
    inout  wire  [15:0] sram_data,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ce_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam int unsigned PH_W = 4;
    localparam logic [PH_W-1:0] HOLD_PH   = PH_W'(WAIT_CYCLES + 1);
    localparam logic [PH_W-1:0] STROBE_PH = PH_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t          state, nxt_state;
    logic [PH_W-1:0] phase, nxt_phase;
    logic [16:0]     addr_q, cur_addr;
    logic [31:0]     wdata_q, cur_wdata;
    logic [3:0]      be_q, cur_be;
    logic            write_q, cur_write;
    logic [31:0]     rd_buf, rd_next;
    logic            data_oe, nxt_doe;
    logic [15:0]     data_out, nxt_dout;
    logic [17:0]     nxt_addr;
    logic            nxt_ce, nxt_we, nxt_oe, nxt_ub, nxt_lb, nxt_ready;
    logic            hold_end, need_hi, hi_sel, capture;
    state_t          first_half;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^bus_addr[1:0];

    // Output enable is a register, so the pins release together with the strobes on reset.
    assign sram_data = data_oe ? data_out : 16'hzzzz;

    // Next state, next registered pin values and read capture.
    always_comb begin
        cur_addr  = (state == IDLE) ? bus_addr[18:2]  : addr_q;
        cur_wdata = (state == IDLE) ? bus_wdata       : wdata_q;
        cur_be    = (state == IDLE) ? bus_byteenable  : be_q;
        cur_write = (state == IDLE) ? bus_write       : write_q;
        hold_end  = (phase == HOLD_PH);
`ifdef SRAM_HALF_SKIP_EN
        need_hi    = |be_q[3:2];
        first_half = (|bus_byteenable[1:0]) ? LO : ((|bus_byteenable[3:2]) ? HI : DONE);
`else
        need_hi    = 1'b1;
        first_half = LO;
`endif
        nxt_state = state;
        nxt_phase = phase;
        case (state)
            IDLE: begin
                nxt_phase = '0;
                if (bus_req) nxt_state = first_half;
            end
            LO: begin
                if (hold_end) begin
                    nxt_phase = '0;
                    nxt_state = need_hi ? HI : DONE;
                end else begin
                    nxt_phase = phase + PH_W'(1);
                end
            end
            HI: begin
                if (hold_end) begin
                    nxt_phase = '0;
                    nxt_state = DONE;
                end else begin
                    nxt_phase = phase + PH_W'(1);
                end
            end
            DONE: begin
`ifdef SRAM_HALF_SKIP_EN
                // An all-disabled access enters DONE without a pulse and waits one cycle.
                nxt_state = bus_ready ? IDLE : DONE;
`else
                nxt_state = IDLE;
`endif
            end
            default: nxt_state = IDLE;
        endcase

        nxt_ce   = 1'b1;
        nxt_we   = 1'b1;
        nxt_oe   = 1'b1;
        nxt_ub   = 1'b1;
        nxt_lb   = 1'b1;
        nxt_doe  = 1'b0;
        nxt_dout = 16'h0000;
        nxt_addr = sram_addr;
        hi_sel   = (nxt_state == HI);
        if (nxt_state == LO || nxt_state == HI) begin
            nxt_ce   = 1'b0;
            nxt_addr = {cur_addr, hi_sel};
            if (cur_write) begin
                nxt_doe  = 1'b1;
                nxt_dout = hi_sel ? cur_wdata[31:16] : cur_wdata[15:0];
                nxt_we   = !(nxt_phase != '0 && nxt_phase <= STROBE_PH);
                nxt_lb   = ~(hi_sel ? cur_be[2] : cur_be[0]);
                nxt_ub   = ~(hi_sel ? cur_be[3] : cur_be[1]);
            end else begin
                nxt_oe = 1'b0;
                nxt_ub = 1'b0;
                nxt_lb = 1'b0;
            end
        end
        nxt_ready = (nxt_state == DONE) && (state != IDLE);

        capture = (state == LO || state == HI) && hold_end && !write_q;
        rd_next = rd_buf;
        if (capture) begin
            if (state == HI) rd_next[31:16] = sram_data;
            else             rd_next[15:0]  = sram_data;
        end
    end

    // State, request latches and registered pin outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            write_q   <= 1'b0;
            rd_buf    <= '0;
            data_oe   <= 1'b0;
            data_out  <= '0;
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
            bus_ready <= 1'b0;
            bus_rdata <= '0;
        end else begin
            state <= nxt_state;
            phase <= nxt_phase;
            if (state == IDLE && bus_req) begin
                addr_q  <= bus_addr[18:2];
                wdata_q <= bus_wdata;
                be_q    <= bus_byteenable;
                write_q <= bus_write;
                rd_buf  <= '0;
            end else begin
                rd_buf <= rd_next;
            end
            data_oe   <= nxt_doe;
            data_out  <= nxt_dout;
            sram_addr <= nxt_addr;
            sram_ce_n <= nxt_ce;
            sram_we_n <= nxt_we;
            sram_oe_n <= nxt_oe;
            sram_ub_n <= nxt_ub;
            sram_lb_n <= nxt_lb;
            bus_ready <= nxt_ready;
            if (nxt_ready && !write_q) bus_rdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: WAIT_CYCLES=1 and WAIT_CYCLES=3 instances, each with a behavioural SRAM.
module tb_sram_ctrl;

`ifdef SRAM_HALF_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam logic [4:0] F_NOWE = 5'b00001;
    localparam logic [4:0] F_LBHI = 5'b00010;
    localparam logic [4:0] F_NOODD = 5'b00100;
    localparam logic [4:0] F_NOCE = 5'b01000;
    localparam logic [4:0] F_NOLANE = 5'b10000;
    localparam int NV = 14;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req1 = 1'b0, req3 = 1'b0, bus_write = 1'b0;
    logic [18:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [3:0]  bus_be = '0;

    wire  [15:0] sd1, sd3;
    logic        rdy1, rdy3, we1, we3, oe1, oe3, ce1, ce3, ub1, ub3, lb1, lb3;
    logic [31:0] rdata1, rdata3;
    logic [17:0] sa1, sa3;

    sram_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .bus_req(req1), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_byteenable(bus_be), .bus_ready(rdy1), .bus_rdata(rdata1),
        .sram_addr(sa1), .sram_data(sd1), .sram_we_n(we1), .sram_oe_n(oe1), .sram_ce_n(ce1),
        .sram_ub_n(ub1), .sram_lb_n(lb1));

    sram_ctrl #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .bus_req(req3), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_byteenable(bus_be), .bus_ready(rdy3), .bus_rdata(rdata3),
        .sram_addr(sa3), .sram_data(sd3), .sram_we_n(we3), .sram_oe_n(oe3), .sram_ce_n(ce3),
        .sram_ub_n(ub3), .sram_lb_n(lb3));

    // Behavioural SRAMs: combinational read, byte-lane write on the clock while WE_n is low.
    logic [15:0] mem1 [0:262143];
    logic [15:0] mem3 [0:262143];
    assign sd1 = (!ce1 && !oe1 && we1) ? mem1[sa1] : 16'hzzzz;
    assign sd3 = (!ce3 && !oe3 && we3) ? mem3[sa3] : 16'hzzzz;
    always @(posedge clk) begin
        if (!ce1 && !we1) begin
            if (!lb1) mem1[sa1][7:0]  <= sd1[7:0];
            if (!ub1) mem1[sa1][15:8] <= sd1[15:8];
        end
        if (!ce3 && !we3) begin
            if (!lb3) mem3[sa3][7:0]  <= sd3[7:0];
            if (!ub3) mem3[sa3][15:8] <= sd3[15:8];
        end
    end

    logic        sel = 1'b0;
    logic        m_rdy, m_we, m_ce, m_ub, m_lb;
    logic [17:0] m_addr;
    logic [31:0] m_rdata;
    assign m_rdy   = sel ? rdy3 : rdy1;
    assign m_we    = sel ? we3 : we1;
    assign m_ce    = sel ? ce3 : ce1;
    assign m_ub    = sel ? ub3 : ub1;
    assign m_lb    = sel ? lb3 : lb1;
    assign m_addr  = sel ? sa3 : sa1;
    assign m_rdata = sel ? rdata3 : rdata1;

    int n_cmp = 0;
    int n_fail = 0;
    int mon_we, mon_ce, mon_odd, mon_ub, mon_lb_lo, mon_lb_hi;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bus access; returns cycles from acceptance to bus_ready (-1 on timeout).
    task automatic run(input bit s, input bit wr, input logic [18:0] a, input logic [31:0] d,
                       input logic [3:0] be, output int lat, output logic [31:0] rd);
        sel = s; bus_write = wr; bus_addr = a; bus_wdata = d; bus_be = be;
        if (s) req3 = 1'b1; else req1 = 1'b1;
        mon_we = 0; mon_ce = 0; mon_odd = 0; mon_ub = 0; mon_lb_lo = 0; mon_lb_hi = 0;
        lat = -1; rd = '0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (!m_we) mon_we++;
            if (!m_ce) begin
                mon_ce++;
                if (m_addr[0]) mon_odd++;
                if (!m_ub) mon_ub++;
                if (!m_lb) begin
                    if (m_addr[0]) mon_lb_hi++; else mon_lb_lo++;
                end
            end
            if (m_rdy) begin
                lat = i; rd = m_rdata;
                break;
            end
        end
        req1 = 1'b0; req3 = 1'b0;
        @(posedge clk); #1;
        chk("ready_single_cycle", 32'(m_rdy), 32'd0);
    endtask

    typedef struct {
        bit          wr;
        logic [18:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic [4:0]  flags;
    } vec_t;

    vec_t        vecs [NV];
    int          lat, n;
    logic [31:0] rd;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 19'h00010, 32'hDEADBEEF, 4'b1111, 32'h0, 7, 5'b0};
        vecs[1]  = '{1'b0, 19'h00010, 32'h0, 4'b1111, 32'hDEADBEEF, 7, F_NOWE};
        vecs[2]  = '{1'b1, 19'hAA000, 32'h11223344, 4'b1111, 32'h0, 7, 5'b0};
        vecs[3]  = '{1'b1, 19'hAA000, 32'h00AA0000, 4'b0100, 32'h0, SKIP ? 4 : 7, F_LBHI};
        vecs[4]  = '{1'b0, 19'hAA000, 32'h0, 4'b1111, 32'h11AA3344, 7, F_NOWE};
        vecs[5]  = '{1'b1, 19'h00020, 32'hCAFE1234, 4'b1111, 32'h0, 7, 5'b0};
        vecs[6]  = '{1'b0, 19'h00020, 32'h0, 4'b0011, SKIP ? 32'h00001234 : 32'hCAFE1234,
                     SKIP ? 4 : 7, SKIP ? (F_NOWE | F_NOODD) : F_NOWE};
        vecs[7]  = '{1'b1, 19'h00020, 32'hFFFFFFFF, 4'b0000, 32'h0, SKIP ? 2 : 7,
                     SKIP ? (F_NOLANE | F_NOCE) : F_NOLANE};
        vecs[8]  = '{1'b0, 19'h00020, 32'h0, 4'b1111, 32'hCAFE1234, 7, F_NOWE};
        vecs[9]  = '{1'b1, 19'h00030, 32'h00000000, 4'b1111, 32'h0, 7, 5'b0};
        vecs[10] = '{1'b1, 19'h00030, 32'hA1B2C3D4, 4'b1001, 32'h0, 7, 5'b0};
        vecs[11] = '{1'b0, 19'h00030, 32'h0, 4'b1111, 32'hA10000D4, 7, F_NOWE};
        vecs[12] = '{1'b0, 19'h00030, 32'h0, 4'b1100, SKIP ? 32'hA1000000 : 32'hA10000D4,
                     SKIP ? 4 : 7, F_NOWE};
        vecs[13] = '{1'b0, 19'h00030, 32'h0, 4'b0000, SKIP ? 32'h0 : 32'hA10000D4,
                     SKIP ? 2 : 7, SKIP ? F_NOCE : F_NOWE};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes1", 32'({ce1, we1, oe1, ub1, lb1}), 32'b11111);
        chk("rst_strobes3", 32'({ce3, we3, oe3, ub3, lb3}), 32'b11111);
        chk("rst_addr", 32'(sa1), 32'h0);
        chk("rst_ready", 32'(rdy1), 32'h0);
        chk("rst_rdata", rdata1, 32'h0);
        chk("rst_data_released", 32'(dut1.data_oe), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < NV; k++) begin
            run(1'b0, vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].be, lat, rd);
            chk($sformatf("v%0d_latency", k), 32'(lat), 32'(vecs[k].exp_lat));
            if (!vecs[k].wr) chk($sformatf("v%0d_rdata", k), rd, vecs[k].exp_rd);
            if (vecs[k].flags[0]) chk($sformatf("v%0d_we_low_cycles", k), 32'(mon_we), 32'd0);
            if (vecs[k].flags[1]) begin
                chk($sformatf("v%0d_ub_low", k), 32'(mon_ub), 32'd0);
                chk($sformatf("v%0d_lb_low_lo", k), 32'(mon_lb_lo), 32'd0);
                chk($sformatf("v%0d_lb_low_hi", k), 32'(mon_lb_hi), 32'd3);
            end
            if (vecs[k].flags[2]) chk($sformatf("v%0d_odd_addr", k), 32'(mon_odd), 32'd0);
            if (vecs[k].flags[3]) chk($sformatf("v%0d_ce_low", k), 32'(mon_ce), 32'd0);
            if (vecs[k].flags[4]) chk($sformatf("v%0d_lane_low", k), 32'(mon_ub + mon_lb_lo + mon_lb_hi), 32'd0);
        end

        chk("mem_lo_half", 32'(mem1[18'h00008]), 32'h0000BEEF);
        chk("mem_hi_half", 32'(mem1[18'h00009]), 32'h0000DEAD);
        chk("mem_byte_write", 32'(mem1[18'h55001]), 32'h000011AA);

        // Reset during the WE_n-low phase of HI
        sel = 1'b0; bus_write = 1'b1; bus_addr = 19'h00040; bus_wdata = 32'h12345678; bus_be = 4'b1111;
        req1 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_we_low", 32'(we1), 32'h0);
        chk("mid_addr_hi", 32'(sa1[0]), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_strobes", 32'({ce1, we1, oe1, ub1, lb1}), 32'b11111);
        chk("mid_rst_data_released", 32'(dut1.data_oe), 32'h0);
        req1 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (rdy1) n++;
            @(posedge clk); #1;
        end
        chk("mid_rst_no_ready", 32'(n), 32'd0);
        run(1'b0, 1'b1, 19'h00040, 32'h12345678, 4'b1111, lat, rd);
        chk("post_rst_wr_latency", 32'(lat), 32'd7);
        run(1'b0, 1'b0, 19'h00040, 32'h0, 4'b1111, lat, rd);
        chk("post_rst_rd_latency", 32'(lat), 32'd7);
        chk("post_rst_rdata", rd, 32'h12345678);

        // WAIT_CYCLES=3 back-to-back write then read with bus_req held
        sel = 1'b1; bus_write = 1'b1; bus_addr = 19'h00100; bus_wdata = 32'h5A5AA5A5; bus_be = 4'b1111;
        req3 = 1'b1;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (rdy3) begin lat = i; break; end
        end
        chk("w3_write_latency", 32'(lat), 32'd11);
        bus_write = 1'b0;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (rdy3) begin lat = i; break; end
        end
        chk("w3_ready_spacing", 32'(lat), 32'd12);
        chk("w3_rdata", rdata3, 32'h5A5AA5A5);
        req3 = 1'b0;
        @(posedge clk); #1;
        chk("w3_mem_lo", 32'(mem3[18'h00080]), 32'h0000A5A5);
        chk("w3_mem_hi", 32'(mem3[18'h00081]), 32'h00005A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
